// File: rtl/song_sequencer.sv
// song_sequencer: steps through a note table in an external synchronous ROM and
// programs a square-wave tone generator with a half-period and an enable.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   song[4:0]         one-hot song select, sampled only when a start is accepted
//   start, stop       1-cycle control pulses; stop wins over start
//   rom_addr          {song index(3), note offset(SLOT_W)} to the note ROM
//   rom_data[27:0]    ROM word one cycle after rom_addr: [27:10] half period, [9:0] ticks
//   tone_half_period  half period to the tone generator, in clk cycles
//   tone_en           tone generator enable
//   playing, done     playback status; done is a level cleared by start or stop
//   note_idx          offset of the sounding note currently loaded
//
// Build option: define SEQ_LOOP_EN to repeat the song at its end instead of stopping.
module song_sequencer #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned TICK_HZ   = 1000,
  parameter int unsigned SLOT_W    = 5,
  parameter int unsigned GAP_TICKS = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        song,
  input  logic              start,
  input  logic              stop,
  output logic [SLOT_W+2:0] rom_addr,
  input  logic [27:0]       rom_data,
  output logic [17:0]       tone_half_period,
  output logic              tone_en,
  output logic              playing,
  output logic              done,
  output logic [SLOT_W-1:0] note_idx
);

  localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned GAP_W    = $clog2(GAP_TICKS + 1);
  localparam int unsigned TICK_W   = (GAP_W > 10) ? GAP_W : 10;
  localparam int unsigned ADDR_W   = SLOT_W + 3;
  localparam bit          HAS_GAP  = (GAP_TICKS != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_LOAD, S_PLAY, S_GAP, S_DONE
  } state_t;

  state_t              r_state,    w_state;
  logic [2:0]          r_idx,      w_idx;
  logic [SLOT_W-1:0]   r_offset,   w_offset;
  logic [ADDR_W-1:0]   r_rom_addr, w_rom_addr;
  logic [17:0]         r_hp,       w_hp;
  logic                r_tone_en,  w_tone_en;
  logic                r_playing,  w_playing;
  logic                r_done,     w_done;
  logic [SLOT_W-1:0]   r_note_idx, w_note_idx;
  logic [PRESC_W-1:0]  r_presc,    w_presc;
  logic [TICK_W-1:0]   r_ticks,    w_ticks;
  logic [TICK_W-1:0]   r_target,   w_target;
  logic                r_sound,    w_sound;

  logic                w_tick, w_tick_last, w_adv, w_end, w_song_ok;
  logic [2:0]          w_sel;
  logic [17:0]         w_hp_in;
  logic [9:0]          w_dur_in;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_offset   <= '0;
      r_rom_addr <= '0;
      r_hp       <= '0;
      r_tone_en  <= 1'b0;
      r_playing  <= 1'b0;
      r_done     <= 1'b0;
      r_note_idx <= '0;
      r_presc    <= '0;
      r_ticks    <= '0;
      r_target   <= '0;
      r_sound    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_idx      <= w_idx;
      r_offset   <= w_offset;
      r_rom_addr <= w_rom_addr;
      r_hp       <= w_hp;
      r_tone_en  <= w_tone_en;
      r_playing  <= w_playing;
      r_done     <= w_done;
      r_note_idx <= w_note_idx;
      r_presc    <= w_presc;
      r_ticks    <= w_ticks;
      r_target   <= w_target;
      r_sound    <= w_sound;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state    = r_state;
    w_idx      = r_idx;
    w_offset   = r_offset;
    w_rom_addr = r_rom_addr;
    w_hp       = r_hp;
    w_tone_en  = r_tone_en;
    w_playing  = r_playing;
    w_done     = r_done;
    w_note_idx = r_note_idx;
    w_presc    = r_presc;
    w_ticks    = r_ticks;
    w_target   = r_target;
    w_sound    = r_sound;
    w_adv      = 1'b0;
    w_end      = 1'b0;
    w_sel      = 3'd0;

    w_hp_in     = rom_data[27:10];
    w_dur_in    = rom_data[9:0];
    w_tick      = (r_presc == PRESC_W'(TICK_DIV - 1));
    w_tick_last = w_tick && ((r_ticks + TICK_W'(1)) == r_target);
    w_song_ok   = (song != 5'd0) && ((song & (song - 5'd1)) == 5'd0);
    for (int i = 0; i < 5; i++) begin
      if (song[i]) w_sel = 3'(i);
    end

    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start && w_song_ok) begin
          w_idx     = w_sel;
          w_offset  = '0;
          w_done    = 1'b0;
          w_playing = 1'b1;
          w_state   = S_FETCH;
        end
      end
      S_FETCH: begin
        w_rom_addr = {r_idx, r_offset};
        w_state    = S_WAIT;
      end
      // ROM registers the address on this edge; its word is valid during LOAD
      S_WAIT: w_state = S_LOAD;
      S_LOAD: begin
        w_presc  = '0;
        w_ticks  = '0;
        w_target = TICK_W'(w_dur_in);
        if (w_dur_in == 10'd0) begin
          if (w_hp_in == 18'd0) w_end = 1'b1;
          else                  w_adv = 1'b1;
        end else if (w_hp_in == 18'd0) begin
          w_tone_en = 1'b0;
          w_sound   = 1'b0;
          w_state   = S_PLAY;
        end else begin
          w_hp       = w_hp_in;
          w_tone_en  = 1'b1;
          w_note_idx = r_offset;
          w_sound    = 1'b1;
          w_state    = S_PLAY;
        end
      end
      S_PLAY: begin
        w_presc = w_tick ? '0 : r_presc + PRESC_W'(1);
        if (w_tick) w_ticks = r_ticks + TICK_W'(1);
        if (w_tick_last) begin
          w_tone_en = 1'b0;
          // Only sounding notes get the articulation gap
          if (r_sound && HAS_GAP) begin
            w_state  = S_GAP;
            w_presc  = '0;
            w_ticks  = '0;
            w_target = TICK_W'(GAP_TICKS);
          end else begin
            w_adv = 1'b1;
          end
        end
      end
      S_GAP: begin
        w_presc = w_tick ? '0 : r_presc + PRESC_W'(1);
        if (w_tick) w_ticks = r_ticks + TICK_W'(1);
        if (w_tick_last) w_adv = 1'b1;
      end
      default: w_state = S_IDLE;
    endcase

    // Advance to the next note, or finish; a full slot counts as an end marker
    if (w_end || (w_adv && (r_offset == '1))) begin
`ifdef SEQ_LOOP_EN
      // An empty song (marker at offset 0) still terminates
      if (w_end && (r_offset == '0)) begin
        w_state   = S_DONE;
        w_done    = 1'b1;
        w_playing = 1'b0;
        w_tone_en = 1'b0;
      end else begin
        w_offset = '0;
        w_state  = S_FETCH;
      end
`else
      w_state   = S_DONE;
      w_done    = 1'b1;
      w_playing = 1'b0;
      w_tone_en = 1'b0;
`endif
    end else if (w_adv) begin
      w_offset = r_offset + SLOT_W'(1);
      w_state  = S_FETCH;
    end

    if (stop) begin
      w_state   = S_IDLE;
      w_tone_en = 1'b0;
      w_playing = 1'b0;
      w_done    = 1'b0;
    end
  end

  assign rom_addr         = r_rom_addr;
  assign tone_half_period = r_hp;
  assign tone_en          = r_tone_en;
  assign playing          = r_playing;
  assign done             = r_done;
  assign note_idx         = r_note_idx;

endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: directed bench for song_sequencer with a behavioural
// synchronous note ROM. Timing: CLK_HZ=1000, TICK_HZ=100 (10 cycles per tick),
// GAP_TICKS=2 (20-cycle gap).
module tb_song_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  song;
  logic        start;
  logic        stop;
  logic [7:0]  rom_addr;
  logic [27:0] rom_data;
  logic [17:0] tone_half_period;
  logic        tone_en;
  logic        playing;
  logic        done;
  logic [4:0]  note_idx;

  logic [27:0] mem [256];

  int tests = 0;
  int fails = 0;
  int n;

  typedef struct {
    logic [4:0]  song;
    logic [17:0] hp;
    logic [9:0]  dur;
    bit          valid;
    int          exp_addr;
    int          exp_on;
  } vec_t;

  vec_t vecs[8];
  int   loop_seq[6] = '{1, 2, 0, 1, 2, 0};

  song_sequencer #(
    .CLK_HZ(1000), .TICK_HZ(100), .SLOT_W(5), .GAP_TICKS(2)
  ) dut (
    .clk(clk), .reset(reset), .song(song), .start(start), .stop(stop),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .tone_half_period(tone_half_period), .tone_en(tone_en),
    .playing(playing), .done(done), .note_idx(note_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= mem[rom_addr];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit cond(input int sel, input int val);
    case (sel)
      0:       return int'(tone_en) == val;
      1:       return int'(rom_addr) == val;
      default: return int'(done) == val;
    endcase
  endfunction

  // Counts falling edges until the selected output reaches val, bounded
  task automatic wait_until(input int sel, input int val, input int bound,
                            input string name, output int cnt);
    cnt = 0;
    while (!cond(sel, val) && cnt < bound) begin
      @(negedge clk);
      cnt++;
    end
    if (!cond(sel, val)) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout after %0d cycles", name, cnt);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Returns at the falling edge right after the edge that samples start
  task automatic start_song(input logic [4:0] s);
    @(negedge clk);
    song  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    song  = ~s;
  endtask

  task automatic set_note(input int a, input logic [17:0] h, input logic [9:0] d);
    logic [7:0] ai;
    ai = a[7:0];
    mem[ai] = {h, d};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    song  = 5'd0;
    start = 1'b0;
    stop  = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 28'd0;

    vecs[0] = '{5'b00011, 18'd0,      10'd0, 1'b0, 0,   0};
    vecs[1] = '{5'b00000, 18'd0,      10'd0, 1'b0, 0,   0};
    vecs[2] = '{5'b11111, 18'd0,      10'd0, 1'b0, 0,   0};
    vecs[3] = '{5'b00100, 18'd300,    10'd3, 1'b1, 64,  30};
    vecs[4] = '{5'b00001, 18'd7,      10'd1, 1'b1, 0,   10};
    vecs[5] = '{5'b10000, 18'h3FFFF,  10'd2, 1'b1, 128, 20};
    vecs[6] = '{5'b01000, 18'd1000,   10'd5, 1'b1, 96,  50};
    vecs[7] = '{5'b00010, 18'd2,      10'd1, 1'b1, 32,  10};

    step(3);
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_hp", int'(tone_half_period), 0);
    chk("rst_tone_en", int'(tone_en), 0);
    chk("rst_playing", int'(playing), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_note_idx", int'(note_idx), 0);
    reset = 1'b0;

`ifdef SEQ_LOOP_EN
    set_note(0, 18'd5, 10'd1);
    set_note(1, 18'd6, 10'd1);
    set_note(2, 18'd0, 10'd0);
    start_song(5'b00001);
    for (int i = 0; i < 6; i++) begin
      wait_until(1, loop_seq[i], 200, "loop_addr", n);
      chk("loop_addr", int'(rom_addr), loop_seq[i]);
      chk("loop_done_low", int'(done), 0);
    end
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("loop_stop_playing", int'(playing), 0);
`else
    for (int i = 0; i < 8; i++) begin
      if (!vecs[i].valid) begin
        start_song(vecs[i].song);
        step(3);
        chk("bad_song_playing", int'(playing), 0);
        chk("bad_song_rom_addr", int'(rom_addr), 0);
        chk("bad_song_tone_en", int'(tone_en), 0);
      end else begin
        set_note(vecs[i].exp_addr, vecs[i].hp, vecs[i].dur);
        set_note(vecs[i].exp_addr + 1, 18'd0, 10'd0);
        start_song(vecs[i].song);
        step(1);
        chk("first_rom_addr", int'(rom_addr), vecs[i].exp_addr);
        chk("start_playing", int'(playing), 1);
        chk("start_clears_done", int'(done), 0);
        step(2);
        chk("tone_on_latency", int'(tone_en), 1);
        chk("tone_hp", int'(tone_half_period), int'(vecs[i].hp));
        chk("note_idx_first", int'(note_idx), 0);
        wait_until(0, 0, 2000, "tone_off", n);
        chk("tone_on_cycles", n, vecs[i].exp_on);
        wait_until(1, vecs[i].exp_addr + 1, 200, "gap_fetch", n);
        chk("gap_then_fetch", n, 21);
        wait_until(2, 1, 50, "end_done", n);
        chk("end_marker_latency", n, 2);
        chk("end_playing", int'(playing), 0);
        chk("end_tone_en", int'(tone_en), 0);
      end
    end

    // Rest between notes, then a zero-length note that is skipped
    set_note(32, 18'd200, 10'd1);
    set_note(33, 18'd0,   10'd4);
    set_note(34, 18'd500, 10'd0);
    set_note(35, 18'd400, 10'd1);
    set_note(36, 18'd0,   10'd0);
    start_song(5'b00010);
    step(3);
    chk("rest_first_hp", int'(tone_half_period), 200);
    wait_until(0, 0, 200, "rest_first_off", n);
    chk("rest_first_on", n, 10);
    wait_until(1, 33, 200, "rest_fetch", n);
    chk("rest_fetch_gap", n, 21);
    @(negedge clk);
    song  = 5'b00001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(1, 34, 200, "rest_len", n);
    chk("rest_len_no_gap", n, 41);
    chk("rest_tone_low", int'(tone_en), 0);
    wait_until(1, 35, 50, "skip_zero", n);
    chk("skip_zero_dur", n, 3);
    wait_until(0, 1, 50, "after_skip_on", n);
    chk("after_skip_latency", n, 2);
    chk("after_skip_hp", int'(tone_half_period), 400);
    chk("after_skip_note_idx", int'(note_idx), 3);
    wait_until(2, 1, 200, "rest_song_done", n);

    // Stop and start in the same cycle mid-note
    start_song(5'b00100);
    step(3);
    chk("ss_tone_on", int'(tone_en), 1);
    step(5);
    @(negedge clk);
    stop  = 1'b1;
    start = 1'b1;
    song  = 5'b00001;
    @(negedge clk);
    stop  = 1'b0;
    start = 1'b0;
    chk("ss_playing", int'(playing), 0);
    chk("ss_tone_en", int'(tone_en), 0);
    chk("ss_done", int'(done), 0);
    chk("ss_hp_held", int'(tone_half_period), 300);
    step(3);
    chk("ss_start_ignored", int'(rom_addr), 64);

    // Stop during the articulation gap
    start_song(5'b00100);
    wait_until(0, 1, 10, "gs_tone_on", n);
    wait_until(0, 0, 100, "gs_tone_off", n);
    step(5);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("gs_playing", int'(playing), 0);
    step(25);
    chk("gs_no_fetch", int'(rom_addr), 64);
    chk("gs_done", int'(done), 0);

    // Asynchronous reset while a note sounds
    start_song(5'b00100);
    wait_until(0, 1, 10, "rp_tone_on", n);
    #2;
    reset = 1'b1;
    #1;
    chk("rp_tone_en", int'(tone_en), 0);
    chk("rp_hp", int'(tone_half_period), 0);
    chk("rp_rom_addr", int'(rom_addr), 0);
    chk("rp_playing", int'(playing), 0);
    @(negedge clk);
    reset = 1'b0;
    start_song(5'b00100);
    step(1);
    chk("rp_restart_addr", int'(rom_addr), 64);
    step(2);
    chk("rp_restart_tone", int'(tone_en), 1);
    wait_until(2, 1, 200, "rp_done", n);

    // Full slot of 32 notes without an end marker
    for (int i = 128; i < 160; i++) set_note(i, 18'd1, 10'd1);
    start_song(5'b10000);
    wait_until(2, 1, 2000, "slot_full_done", n);
    chk("slot_full_cycles", n, 1056);
    chk("slot_full_note_idx", int'(note_idx), 31);
    chk("slot_full_rom_addr", int'(rom_addr), 159);
    chk("slot_full_playing", int'(playing), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
